input_conditioner: RTL and testbench

//  Multi-channel front end for asynchronous push-button/switch inputs.
//  Per channel: N-stage synchroniser -> counter debouncer -> registered edge detector.

---
 rtl/input_conditioner.sv | 99 +++++++++
 tb/tb_input_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel pin front end: per channel synchroniser -> counter debouncer -> edge detector.
// Optional long-press detection is built when the LONG_PRESS_EN macro is defined.
module input_conditioner #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned LONG_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] level_o,
    output logic [CH-1:0] edge_o,
    output logic [CH-1:0] long_o
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    // Any EDGE_MODE other than 0 or 1 reports both directions.
    localparam bit RISE_EN = (EDGE_MODE != 1);
    localparam bit FALL_EN = (EDGE_MODE != 0);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be 2..4");
    end
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("input_conditioner: DB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("input_conditioner: LONG_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   edge_q;
        logic                   differ_c;
        logic                   toggle_c;

        assign differ_c = sync_q[SYNC_STAGES-1] ^ level_q;
        assign toggle_c = differ_c && (cnt_q == CNT_MAX);

        // Sync chain, debounce counter and edge pulse share one register process.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                level_q <= 1'b0;
                edge_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
                if (!differ_c) begin
                    cnt_q <= '0;
                end else if (toggle_c) begin
                    cnt_q   <= '0;
                    level_q <= ~level_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                edge_q <= toggle_c && (level_q ? FALL_EN : RISE_EN);
            end
        end

        assign level_o[i] = level_q;
        assign edge_o[i]  = edge_q;

`ifdef LONG_PRESS_EN
        localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

        logic [HOLD_W-1:0] hold_q;
        logic              long_q;

        // Saturating hold counter fires once per press and re-arms on release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else if (!level_q) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= (hold_q == HOLD_FIRE);
                if (hold_q != HOLD_MAX) begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
            end
        end

        assign long_o[i] = long_q;
`else
        assign long_o[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a rising-edge instance and a both-edge instance
// share the same pins; expected output events are queued by the stimulus and popped by a monitor.
module tb_input_conditioner;

    localparam int unsigned CH   = 4;
    localparam int unsigned LONG = 50;
`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CH-1:0] din   = 4'hF;
    logic [CH-1:0] lvl0, edg0, lng0, lvl2, edg2, lng2;

    input_conditioner #(
        .CH(CH), .SYNC_STAGES(2), .DB_CYCLES(16), .EDGE_MODE(0), .LONG_CYCLES(LONG)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .level_o(lvl0), .edge_o(edg0), .long_o(lng0)
    );

    input_conditioner #(
        .CH(CH), .SYNC_STAGES(2), .DB_CYCLES(16), .EDGE_MODE(2), .LONG_CYCLES(LONG)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .level_o(lvl2), .edge_o(edg2), .long_o(lng2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] l0, e0, g0, l2, e2, g2;
    } ev_t;

    ev_t sb[$];
    ev_t ev;
    int  n_chk  = 0;
    int  n_fail = 0;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Queue the expected output snapshot for cycle c; both instances share level and long.
    task automatic push(int c, logic [3:0] lvl, logic [3:0] e0, logic [3:0] e2, logic [3:0] g);
        ev_t e;
        e.c  = c;
        e.l0 = lvl; e.e0 = e0; e.g0 = g;
        e.l2 = lvl; e.e2 = e2; e.g2 = g;
        sb.push_back(e);
    endtask

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_level"}, 32'({lvl2, lvl0}), 0);
        chk({tag, "_edge"},  32'({edg2, edg0}), 0);
        chk({tag, "_long"},  32'({lng2, lng0}), 0);
    endtask

    // Monitor: any level change or pulse is an output event and must match the queue head.
    logic [3:0] p0 = '0;
    logic [3:0] p2 = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (lvl0 != p0 || lvl2 != p2 || |edg0 || |edg2 || |lng0 || |lng2) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event cycle=%0d actual lvl=%h/%h edge=%h/%h long=%h/%h required none",
                             cyc, lvl0, lvl2, edg0, edg2, lng0, lng2);
                end else begin
                    ev = sb.pop_front();
                    chk("event_cycle", cyc, ev.c);
                    chk("level_m0", 32'(lvl0), 32'(ev.l0));
                    chk("edge_m0",  32'(edg0), 32'(ev.e0));
                    chk("long_m0",  32'(lng0), 32'(ev.g0));
                    chk("level_m2", 32'(lvl2), 32'(ev.l2));
                    chk("edge_m2",  32'(edg2), 32'(ev.e2));
                    chk("long_m2",  32'(lng2), 32'(ev.g2));
                end
            end
        end
        p0 = lvl0;
        p2 = lvl2;
    end

    task automatic press(logic [3:0] mask, int hold, logic [3:0] e0r, logic [3:0] e2r,
                         logic [3:0] e0f, logic [3:0] e2f, bit long_exp);
        int c;
        c = cyc;
        din = din | mask;
        push(c + 18, mask, e0r, e2r, 4'h0);
        if (long_exp) push(c + 18 + int'(LONG), mask, 4'h0, 4'h0, mask);
        wait_n(hold);
        c = cyc;
        din = din & ~mask;
        push(c + 18, 4'h0, e0f, e2f, 4'h0);
    endtask

    initial begin
        int c;
        // Reset with all pins high, checked before the first edge and for 5 cycles.
        rst_n = 1'b0;
        din   = 4'hF;
        #1;
        chk_zero("reset_t0");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_zero("reset_hold");
        end
        din = 4'h0;
        wait_n(1);
        rst_n = 1'b1;
        wait_n(5);

        // Clean press on channel 0.
        press(4'h1, 40, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
        wait_n(30);

        // Bounce on channel 1: 5-cycle toggles must never pass.
        for (int k = 0; k < 12; k++) begin
            din[1] = ~din[1];
            wait_n(5);
        end
        din[1] = 1'b0;
        wait_n(30);

        // Debounce boundary: 15-cycle pulse rejected, 16-cycle pulse accepted.
        din[1] = 1'b1;
        wait_n(15);
        din[1] = 1'b0;
        wait_n(30);
        press(4'h2, 16, 4'h2, 4'h2, 4'h0, 4'h2, 1'b0);
        wait_n(40);

        // Simultaneous channels 0 and 3.
        press(4'h9, 30, 4'h9, 4'h9, 4'h0, 4'h9, 1'b0);
        wait_n(30);

        // Reset mid-count discards debounce progress on channel 2.
        din[2] = 1'b1;
        wait_n(10);
        rst_n = 1'b0;
        wait_n(1);
        chk_zero("reset_mid");
        wait_n(1);
        rst_n = 1'b1;
        c = cyc;
        push(c + 18, 4'h4, 4'h4, 4'h4, 4'h0);
        wait_n(25);
        c = cyc;
        din[2] = 1'b0;
        push(c + 18, 4'h0, 4'h0, 4'h4, 4'h0);
        wait_n(30);

        // Long press: 100-cycle hold fires, 30-cycle hold does not, 60-cycle hold fires again.
        press(4'h1, 100, 4'h1, 4'h1, 4'h0, 4'h1, LP);
        wait_n(30);
        press(4'h1, 30, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
        wait_n(30);
        press(4'h1, 60, 4'h1, 4'h1, 4'h0, 4'h1, LP);
        wait_n(40);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
